// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer
//   Per-instruction phase sequencer for the multi-cycle CPU datapath. Issues
//   fetch, memory, register-write and PC-update enables. Supports free-run and
//   single-step execution, stalls on switch (MMIO) reads until the user presses
//   confirm, and parks in a terminal HALT state on ecall/halt.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   STEP_WAIT | idle between instructions, waiting for run or a step edge (7)
//   FETCH     | instruction fetch, if_en high (0)
//   DECODE    | decoder outputs valid, io/halt flags captured (1)
//   EXEC      | execute; choose HALT, IO_WAIT or MEM (2)
//   MEM       | data-memory access, mem_en high (3)
//   WB        | register write + PC update, count retires (4)
//   IO_WAIT   | stalled on a switch read until a confirm edge (5)
//   HALT      | terminal; only rst leaves (6)
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   run             1 = free-run, 0 = single-step
//   step            debounced step button level
//   io_read         current instruction reads the switch MMIO (valid in DECODE)
//   halt_req        current instruction is ecall/halt (valid in DECODE)
//   io_confirm      debounced confirm button level
//   if_en, mem_en, reg_we_en, pc_en   phase enables
//   phase           current state encoding
//   waiting_io      high in IO_WAIT
//   halted          high in HALT
//   instr_count     retired-instruction count (wraps silently)

module cpu_step_sequencer #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   step,
    input  logic                   io_read,
    input  logic                   halt_req,
    input  logic                   io_confirm,
    output logic                   if_en,
    output logic                   mem_en,
    output logic                   reg_we_en,
    output logic                   pc_en,
    output logic [2:0]             phase,
    output logic                   waiting_io,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXEC      = 3'd2,
        S_MEM       = 3'd3,
        S_WB        = 3'd4,
        S_IO_WAIT   = 3'd5,
        S_HALT      = 3'd6,
        S_STEP_WAIT = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   step_q;
    logic   confirm_q;
    logic   io_flag;
    logic   halt_flag;
    logic   step_rise;
    logic   confirm_rise;

    assign step_rise    = step & ~step_q;
    assign confirm_rise = io_confirm & ~confirm_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_STEP_WAIT: if (run || step_rise) state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXEC;
            S_EXEC: begin
                // halt takes priority over a simultaneous switch read
                if (halt_flag)    state_nxt = S_HALT;
                else if (io_flag) state_nxt = S_IO_WAIT;
                else              state_nxt = S_MEM;
            end
            S_IO_WAIT:   if (confirm_rise) state_nxt = S_MEM;
            S_MEM:       state_nxt = S_WB;
            S_WB:        state_nxt = run ? S_FETCH : S_STEP_WAIT;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_STEP_WAIT;
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up
    // cycle-for-cycle with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_STEP_WAIT;
            // reset to 1 so a button held through reset yields no edge
            step_q      <= 1'b1;
            confirm_q   <= 1'b1;
            io_flag     <= 1'b0;
            halt_flag   <= 1'b0;
            instr_count <= '0;
            if_en       <= 1'b0;
            mem_en      <= 1'b0;
            reg_we_en   <= 1'b0;
            pc_en       <= 1'b0;
            waiting_io  <= 1'b0;
            halted      <= 1'b0;
            phase       <= S_STEP_WAIT;
        end else begin
            state     <= state_nxt;
            step_q    <= step;
            confirm_q <= io_confirm;
            if (state == S_DECODE) begin
                io_flag   <= io_read;
                halt_flag <= halt_req;
            end else if (state == S_FETCH) begin
                io_flag   <= 1'b0;
                halt_flag <= 1'b0;
            end
            if (state == S_WB) instr_count <= instr_count + COUNT_WIDTH'(1);
            if_en      <= (state_nxt == S_FETCH);
            mem_en     <= (state_nxt == S_MEM);
            reg_we_en  <= (state_nxt == S_WB);
            pc_en      <= (state_nxt == S_WB);
            waiting_io <= (state_nxt == S_IO_WAIT);
            halted     <= (state_nxt == S_HALT);
            phase      <= state_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
module tb_cpu_step_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          io_read = 1'b0;
    logic          halt_req = 1'b0;
    logic          io_confirm = 1'b0;
    logic          if_en, mem_en, reg_we_en, pc_en, waiting_io, halted;
    logic [2:0]    phase;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    cpu_step_sequencer #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .io_read(io_read),
        .halt_req(halt_req), .io_confirm(io_confirm), .if_en(if_en),
        .mem_en(mem_en), .reg_we_en(reg_we_en), .pc_en(pc_en), .phase(phase),
        .waiting_io(waiting_io), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Reference model: where we are within the current instruction
    // (position 0..4 = fetch, decode, exec, mem, writeback), plus idle /
    // stalled / halted conditions and the retired count.
    bit m_idle, m_halt, m_stall, m_io, m_hl;
    int m_pos, m_count;
    bit m_step_prev, m_conf_prev;

    task automatic m_update();
        bit sr, cr;
        if (rst) begin
            m_idle = 1; m_halt = 0; m_stall = 0; m_io = 0; m_hl = 0;
            m_pos = 0; m_count = 0; m_step_prev = 1; m_conf_prev = 1;
            return;
        end
        sr = step && !m_step_prev;
        cr = io_confirm && !m_conf_prev;
        m_step_prev = step;
        m_conf_prev = io_confirm;
        if (m_halt) return;
        if (m_idle) begin
            if (run || sr) begin m_idle = 0; m_pos = 0; end
        end else if (m_stall) begin
            if (cr) begin m_stall = 0; m_pos = 3; end
        end else begin
            case (m_pos)
                0: m_pos = 1;
                1: begin m_io = io_read; m_hl = halt_req; m_pos = 2; end
                2: if (m_hl) m_halt = 1; else if (m_io) m_stall = 1; else m_pos = 3;
                3: m_pos = 4;
                default: begin
                    m_count = (m_count + 1) % (1 << CW);
                    if (run) m_pos = 0; else m_idle = 1;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        int  exp_phase;
        bit  active;
        active    = !m_halt && !m_idle && !m_stall;
        exp_phase = m_halt ? 6 : m_idle ? 7 : m_stall ? 5 : m_pos;
        chk("phase", 32'(phase), 32'(exp_phase));
        chk("if_en", 32'(if_en), 32'(active && m_pos == 0));
        chk("mem_en", 32'(mem_en), 32'(active && m_pos == 3));
        chk("reg_we_en", 32'(reg_we_en), 32'(active && m_pos == 4));
        chk("pc_en", 32'(pc_en), 32'(active && m_pos == 4));
        chk("waiting_io", 32'(waiting_io), 32'(m_stall && !m_halt));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("instr_count", 32'(instr_count), 32'(m_count));
    endtask

    // inputs are driven between edges; model advances on the edge,
    // outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
        compare_all();
    endtask

    int pulses;
    bit saw_wrap;
    logic [CW-1:0] prev_cnt;

    initial begin
        // reset state
        rst = 1; run = 1;
        tick(); tick();
        chk("reset_phase", 32'(phase), 32'd7);
        chk("reset_count", 32'(instr_count), 32'd0);

        // free-run: 5-cycle instructions back to back
        rst = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pc_en) pulses++;
            if (i < 5) chk("freerun_phase_seq", 32'(phase), 32'(i));
        end
        chk("freerun_pc_pulses", 32'(pulses), 32'd4);
        tick();
        chk("freerun_count", 32'(instr_count), 32'd4);

        // single step, step held through reset
        rst = 1; run = 0; step = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("step_held_no_fetch", 32'(phase), 32'd7);
        step = 0; tick();
        step = 1; tick();
        chk("step_fetch", 32'(phase), 32'd0);
        step = 0; tick();
        step = 1; tick();              // dropped second edge
        step = 0;
        tick(); tick();
        chk("step_wb", 32'(pc_en), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("step_back_idle", 32'(phase), 32'd7);
        chk("step_count", 32'(instr_count), 32'd1);

        // IO stall; early confirm edge in FETCH ignored
        step = 1; tick();
        io_read = 1; io_confirm = 1; tick();   // FETCH -> DECODE
        chk("io_decode", 32'(phase), 32'd1);
        io_confirm = 0; step = 0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("io_wait_hold", 32'(waiting_io), 32'd1);
        end
        io_read = 0; io_confirm = 1; tick();
        chk("io_to_mem", 32'(phase), 32'd3);
        io_confirm = 0; tick();
        chk("io_to_wb", 32'(phase), 32'd4);
        tick();

        // halt wins over io; inputs ignored in HALT
        rst = 1; tick();
        rst = 0; run = 1; halt_req = 1; io_read = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("halt_enter", 32'(phase), 32'd6);
        halt_req = 0; io_read = 0;
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom); step = ~step; io_confirm = ~io_confirm;
            tick();
            chk("halt_sticky", 32'(halted), 32'd1);
        end
        rst = 1; tick();
        chk("halt_reset", 32'(phase), 32'd7);

        // reset during MEM abandons the instruction
        rst = 0; run = 0; step = 0; io_confirm = 0; tick();
        step = 1; tick();
        tick(); tick(); tick();
        chk("mem_reached", 32'(phase), 32'd3);
        rst = 1; tick();
        chk("mem_rst_phase", 32'(phase), 32'd7);
        chk("mem_rst_pc", 32'(pc_en), 32'd0);
        chk("mem_rst_count", 32'(instr_count), 32'd0);

        // counter wrap at 4 bits
        rst = 0; run = 1; step = 0;
        saw_wrap = 0;
        prev_cnt = instr_count;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (prev_cnt == 4'd15 && instr_count == 4'd0) saw_wrap = 1;
            prev_cnt = instr_count;
        end
        chk("count_wrap", 32'(saw_wrap), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            run        = ($urandom_range(0, 3) != 0);
            step       = 1'($urandom);
            io_confirm = 1'($urandom);
            io_read    = ($urandom_range(0, 2) == 0);
            halt_req   = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
